// File: rtl/pe_row_scheduler.sv
// Row-level sequencer for one processing element: walks every K-tap window of an
// ifmap row, tags the PE pipeline, captures each partial sum and hands it downstream.
module pe_row_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int KMAX       = 7,
    parameter int ADDR_W     = 8,
    parameter int PIPE_LAT   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(KMAX+1)-1:0] kernel_size,
    input  logic [ADDR_W-1:0]         row_len,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         ifmap_addr,
    output logic [$clog2(KMAX)-1:0]   fltr_addr,
    output logic                      pe_en,
    output logic                      first_tap,
    output logic                      last_tap,
    input  logic [2*DATA_WIDTH-1:0]   psum_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_W-1:0]         out_idx
);

    localparam int KW  = $clog2(KMAX + 1);
    localparam int FW  = $clog2(KMAX);
    localparam int PW  = PIPE_LAT - 1;
    localparam int PSW = 2 * DATA_WIDTH;

    localparam logic [KW-1:0]     K_ONE  = KW'(1);
    localparam logic [KW-1:0]     K_ZERO = KW'(0);
    localparam logic [FW-1:0]     F_ONE  = FW'(1);
    localparam logic [FW-1:0]     F_ZERO = FW'(0);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t              r_state;
    logic [KW-1:0]       r_k_cfg;
    logic [ADDR_W-1:0]   r_w_cfg;
    logic [ADDR_W-1:0]   r_o_last;
    logic [ADDR_W-1:0]   r_o;
    logic [KW-1:0]       r_k;
    logic                r_busy;
    logic                r_done;
    logic                r_cfg_err;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_ifmap_addr;
    logic [FW-1:0]       r_fltr_addr;
    logic [PW-1:0]       r_en_pipe;
    logic [PW-1:0]       r_first_pipe;
    logic [PW-1:0]       r_last_pipe;
    logic                r_cap;
    logic                r_out_valid;
    logic [PSW-1:0]      r_out_data;
    logic [ADDR_W-1:0]   r_out_idx;

    logic [31:0]         w_k_wide;
    logic [31:0]         w_w_wide;
    logic [ADDR_W-1:0]   w_k_addr;
    logic                w_cfg_bad;
    logic                w_k_last;
    logic                w_tag_first;
    logic                w_tag_last;

    // Configuration legality, tap position and the tag bits that accompany each read.
    always_comb begin
        w_k_wide    = {{(32-KW){1'b0}}, r_k_cfg};
        w_w_wide    = {{(32-ADDR_W){1'b0}}, r_w_cfg};
        w_k_addr    = {{(ADDR_W-KW){1'b0}}, r_k_cfg};
        w_cfg_bad   = (w_k_wide == 32'd0) || (w_k_wide > 32'(KMAX)) || (w_w_wide < w_k_wide);
        w_k_last    = (r_k == (r_k_cfg - K_ONE));
        w_tag_first = r_rd_en && (r_k == K_ZERO);
        w_tag_last  = r_rd_en && w_k_last;
    end

    // Row sequencer; r_rd_en and the addresses always describe the tap r_k of window r_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_k_cfg      <= K_ZERO;
            r_w_cfg      <= A_ZERO;
            r_o_last     <= A_ZERO;
            r_o          <= A_ZERO;
            r_k          <= K_ZERO;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_rd_en      <= 1'b0;
            r_ifmap_addr <= A_ZERO;
            r_fltr_addr  <= F_ZERO;
            r_out_valid  <= 1'b0;
            r_out_data   <= {PSW{1'b0}};
            r_out_idx    <= A_ZERO;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k_cfg   <= kernel_size;
                        r_w_cfg   <= row_len;
                        r_busy    <= 1'b1;
                        r_cfg_err <= 1'b0;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_cfg_bad) begin
                        r_cfg_err <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_FIN;
                    end else begin
                        r_o          <= A_ZERO;
                        r_k          <= K_ZERO;
                        r_o_last     <= r_w_cfg - w_k_addr;
                        r_rd_en      <= 1'b1;
                        r_ifmap_addr <= A_ZERO;
                        r_fltr_addr  <= F_ZERO;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_k_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k          <= r_k + K_ONE;
                        r_ifmap_addr <= r_ifmap_addr + A_ONE;
                        r_fltr_addr  <= r_fltr_addr + F_ONE;
                    end
                end
                S_DRAIN: begin
                    // r_cap marks the cycle in which the final-tap accumulation is on psum_in.
                    if (r_cap) begin
                        r_out_data  <= psum_in;
                        r_out_idx   <= r_o;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_o == r_o_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_o          <= r_o + A_ONE;
                            r_k          <= K_ZERO;
                            r_rd_en      <= 1'b1;
                            r_ifmap_addr <= r_o + A_ONE;
                            r_fltr_addr  <= F_ZERO;
                            r_state      <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rd_en     <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Tag pipe: delays rd_en/first/last so they meet the operands at the PE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_pipe    <= {PW{1'b0}};
            r_first_pipe <= {PW{1'b0}};
            r_last_pipe  <= {PW{1'b0}};
            r_cap        <= 1'b0;
        end else begin
            r_en_pipe[0]    <= r_rd_en;
            r_first_pipe[0] <= w_tag_first;
            r_last_pipe[0]  <= w_tag_last;
            for (int i = 1; i < PW; i++) begin
                r_en_pipe[i]    <= r_en_pipe[i-1];
                r_first_pipe[i] <= r_first_pipe[i-1];
                r_last_pipe[i]  <= r_last_pipe[i-1];
            end
            r_cap <= r_en_pipe[PW-1] && r_last_pipe[PW-1];
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;
    assign rd_en      = r_rd_en;
    assign ifmap_addr = r_ifmap_addr;
    assign fltr_addr  = r_fltr_addr;
    assign pe_en      = r_en_pipe[PW-1];
    assign first_tap  = r_first_pipe[PW-1];
    assign last_tap   = r_last_pipe[PW-1];
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Directed bench for pe_row_scheduler with a 3-stage model PE
// (ifmap[a] = a+1, filter[f] = f+2) feeding psum_in.
module tb_pe_row_scheduler;

    localparam int DATA_WIDTH = 16;
    localparam int KMAX       = 7;
    localparam int ADDR_W     = 8;
    localparam int PIPE_LAT   = 3;
    localparam int KW         = $clog2(KMAX + 1);
    localparam int FW         = $clog2(KMAX);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [KW-1:0]           kernel_size;
    logic [ADDR_W-1:0]       row_len;
    logic                    busy, done, cfg_err, rd_en, pe_en, first_tap, last_tap;
    logic [ADDR_W-1:0]       ifmap_addr;
    logic [FW-1:0]           fltr_addr;
    logic [2*DATA_WIDTH-1:0] psum_in;
    logic                    out_valid, out_ready;
    logic [2*DATA_WIDTH-1:0] out_data;
    logic [ADDR_W-1:0]       out_idx;

    int n_checks = 0;
    int n_fail   = 0;

    pe_row_scheduler #(
        .DATA_WIDTH(DATA_WIDTH), .KMAX(KMAX), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size), .row_len(row_len),
        .busy(busy), .done(done), .cfg_err(cfg_err), .rd_en(rd_en),
        .ifmap_addr(ifmap_addr), .fltr_addr(fltr_addr), .pe_en(pe_en),
        .first_tap(first_tap), .last_tap(last_tap), .psum_in(psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // Model PE: buffer read stage, multiplier stage, then accumulator.
    logic [31:0] m_prod1, m_prod2, m_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prod1 <= 32'd0;
            m_prod2 <= 32'd0;
            m_acc   <= 32'd0;
        end else begin
            m_prod1 <= rd_en ? (({24'd0, ifmap_addr} + 32'd1) * ({29'd0, fltr_addr} + 32'd2)) : 32'd0;
            m_prod2 <= m_prod1;
            if (pe_en) m_acc <= (first_tap ? 32'd0 : m_acc) + m_prod2;
        end
    end
    assign psum_in = m_acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] q_ia[$];
    logic [FW-1:0]     q_fa[$];
    int                q_rd_cyc[$];
    int                q_pe_cyc[$];
    logic              q_first[$];
    logic              q_last[$];
    logic [31:0]       q_psum[$];
    logic [31:0]       q_data[$];
    logic [ADDR_W-1:0] q_idx[$];
    int                done_cnt = 0;
    int                done_cyc = 0;
    logic              done_err = 1'b0;
    int                vld_cnt  = 0;
    logic              m_cap_pending = 1'b0;

    // Recorder: samples DUT activity mid-cycle; the test tasks judge it.
    always @(negedge clk) begin
        if (rd_en) begin
            q_ia.push_back(ifmap_addr);
            q_fa.push_back(fltr_addr);
            q_rd_cyc.push_back(cyc);
        end
        if (pe_en) begin
            q_pe_cyc.push_back(cyc);
            q_first.push_back(first_tap);
            q_last.push_back(last_tap);
        end
        if (m_cap_pending) q_psum.push_back(psum_in);
        m_cap_pending <= pe_en && last_tap;
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_idx.push_back(out_idx);
        end
        if (out_valid) vld_cnt <= vld_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_err <= cfg_err;
        end
    end

    task automatic clear_rec();
        q_ia.delete(); q_fa.delete(); q_rd_cyc.delete(); q_pe_cyc.delete();
        q_first.delete(); q_last.delete(); q_psum.delete(); q_data.delete(); q_idx.delete();
    endtask

    task automatic pulse_start(input int k, input int w, output int s);
        @(posedge clk); #1;
        start = 1'b1; kernel_size = KW'(k); row_len = ADDR_W'(w); s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit timed_out);
        int base;
        base = done_cnt;
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (done_cnt != base) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; kernel_size = '0; row_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, cfg_err, rd_en, pe_en, first_tap, last_tap, out_valid} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, done, cfg_err, rd_en, pe_en, first_tap, last_tap, out_valid});
        end
        n_checks++;
        if ({out_data, out_idx, ifmap_addr, fltr_addr} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_data: out_data=%0d out_idx=%0d ia=%0d fa=%0d want all 0",
                     out_data, out_idx, ifmap_addr, fltr_addr);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int exp_ia[9] = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        int exp_d[3]  = '{20, 29, 38};
        int s, nd;
        bit to;
        clear_rec();
        out_ready = 1'b1;
        nd = done_cnt;
        pulse_start(3, 5, s);
        n_checks++;
        if (busy !== 1'b1 || cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy: busy=%b cfg_err=%b want 1 0", busy, cfg_err);
        end
        wait_done(200, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL basic_timeout: done not seen want done"); end
        n_checks++;
        if (q_ia.size() != 9 || q_pe_cyc.size() != 9) begin
            n_fail++; $display("FAIL basic_rd_count: rd=%0d pe=%0d want 9 9", q_ia.size(), q_pe_cyc.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (q_ia[i] !== ADDR_W'(exp_ia[i]) || q_fa[i] !== FW'(i % 3)) begin
                    n_fail++;
                    $display("FAIL basic_addr[%0d]: ia=%0d fa=%0d want %0d %0d", i, q_ia[i], q_fa[i], exp_ia[i], i % 3);
                end
                n_checks++;
                if (q_pe_cyc[i] != q_rd_cyc[i] + PIPE_LAT - 1 || q_first[i] !== (i % 3 == 0) ||
                    q_last[i] !== (i % 3 == 2)) begin
                    n_fail++;
                    $display("FAIL basic_tag[%0d]: pe_cyc=%0d first=%b last=%b want %0d %b %b", i, q_pe_cyc[i],
                             q_first[i], q_last[i], q_rd_cyc[i] + PIPE_LAT - 1, i % 3 == 0, i % 3 == 2);
                end
            end
            n_checks++;
            if (q_rd_cyc[0] != s + 2 || q_rd_cyc[3] - q_rd_cyc[0] != 3 + PIPE_LAT + 1) begin
                n_fail++;
                $display("FAIL basic_timing: first_rd=%0d period=%0d want %0d %0d", q_rd_cyc[0],
                         q_rd_cyc[3] - q_rd_cyc[0], s + 2, 3 + PIPE_LAT + 1);
            end
            n_checks++;
            if (done_cyc != q_rd_cyc[8] + 5) begin
                n_fail++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, q_rd_cyc[8] + 5);
            end
        end
        n_checks++;
        if (q_data.size() != 3) begin
            n_fail++; $display("FAIL basic_results: got %0d results want 3", q_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (q_data[i] !== 32'(exp_d[i]) || q_idx[i] !== ADDR_W'(i)) begin
                    n_fail++;
                    $display("FAIL basic_data[%0d]: data=%0d idx=%0d want %0d %0d", i, q_data[i], q_idx[i], exp_d[i], i);
                end
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (done_cnt - nd != 1 || done_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: dones=%0d cfg_err=%b busy=%b want 1 0 0", done_cnt - nd, done_err, busy);
        end
    endtask

    task automatic test_backpressure();
        int s;
        bit to, found, stable, rd_seen;
        logic [31:0] hold_d;
        logic [ADDR_W-1:0] hold_i;
        clear_rec();
        out_ready = 1'b0;
        pulse_start(2, 3, s);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL bp_valid: out_valid never rose want 1"); end
        hold_d = out_data; hold_i = out_idx; stable = 1'b1; rd_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== hold_d || out_idx !== hold_i) stable = 1'b0;
            if (rd_en) rd_seen = 1'b1;
        end
        n_checks++;
        if (!stable || rd_seen || hold_d !== 32'd8 || hold_i !== 8'd0) begin
            n_fail++;
            $display("FAIL bp_stall: stable=%b rd_seen=%b data=%0d idx=%0d want 1 0 8 0", stable, rd_seen, hold_d, hold_i);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rd_en !== 1'b1 || ifmap_addr !== 8'd1 || fltr_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_resume: rd_en=%b ia=%0d fa=%0d want 1 1 0", rd_en, ifmap_addr, fltr_addr);
        end
        wait_done(100, to);
        n_checks++;
        if (to || q_data.size() != 2) begin
            n_fail++; $display("FAIL bp_count: timeout=%b results=%0d want 0 2", to, q_data.size());
        end else begin
            n_checks++;
            if (q_data[1] !== 32'd13 || q_idx[1] !== 8'd1) begin
                n_fail++; $display("FAIL bp_data: data=%0d idx=%0d want 13 1", q_data[1], q_idx[1]);
            end
        end
    endtask

    task automatic test_cfg_err();
        // KMAX+1 does not fit the kernel_size port and arrives as 0.
        int ks[3] = '{0, KMAX + 1, 4};
        int ws[3] = '{5, 5, 3};
        int s, vb;
        bit to;
        for (int c = 0; c < 3; c++) begin
            clear_rec();
            vb = vld_cnt;
            pulse_start(ks[c], ws[c], s);
            wait_done(20, to);
            n_checks++;
            if (to || done_cyc != s + 2 || done_err !== 1'b1) begin
                n_fail++;
                $display("FAIL cfg_err[%0d]: timeout=%b done_cyc=%0d err=%b want 0 %0d 1", c, to, done_cyc, done_err, s + 2);
            end
            repeat (2) @(posedge clk);
            #1;
            n_checks++;
            if (q_ia.size() != 0 || vld_cnt != vb || cfg_err !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_quiet[%0d]: reads=%0d valids=%0d cfg_err=%b busy=%b want 0 0 1 0",
                         c, q_ia.size(), vld_cnt - vb, cfg_err, busy);
            end
        end
    endtask

    task automatic test_k1();
        int s;
        bit to;
        clear_rec();
        out_ready = 1'b1;
        pulse_start(1, 4, s);
        wait_done(200, to);
        n_checks++;
        if (to || q_data.size() != 4 || q_pe_cyc.size() != 4 || q_psum.size() != 4 || done_err !== 1'b0) begin
            n_fail++;
            $display("FAIL k1_count: timeout=%b results=%0d pe=%0d psum=%0d err=%b want 0 4 4 4 0",
                     to, q_data.size(), q_pe_cyc.size(), q_psum.size(), done_err);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_data[i] !== 32'(2 * (i + 1)) || q_idx[i] !== ADDR_W'(i) || q_data[i] !== q_psum[i] ||
                    q_first[i] !== 1'b1 || q_last[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL k1_win[%0d]: data=%0d idx=%0d psum=%0d first=%b last=%b want %0d %0d %0d 1 1",
                             i, q_data[i], q_idx[i], q_psum[i], q_first[i], q_last[i], 2 * (i + 1), i, 2 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_restart();
        int exp_d[3] = '{8, 13, 18};
        int s, s2, nd;
        bit to;
        clear_rec();
        out_ready = 1'b1;
        nd = done_cnt;
        pulse_start(2, 4, s);
        repeat (4) @(posedge clk);
        pulse_start(1, 6, s2);
        wait_done(300, to);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (to || done_cnt - nd != 1 || q_ia.size() != 6 || q_data.size() != 3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_count: timeout=%b dones=%0d reads=%0d results=%0d busy=%b want 0 1 6 3 0",
                     to, done_cnt - nd, q_ia.size(), q_data.size(), busy);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (q_data[i] !== 32'(exp_d[i]) || q_idx[i] !== ADDR_W'(i)) begin
                    n_fail++;
                    $display("FAIL restart_data[%0d]: data=%0d idx=%0d want %0d %0d", i, q_data[i], q_idx[i], exp_d[i], i);
                end
            end
        end
    endtask

    task automatic test_reset_drain();
        int exp_d[3] = '{20, 29, 38};
        int s, nd;
        bit to, found;
        clear_rec();
        out_ready = 1'b1;
        nd = done_cnt;
        pulse_start(3, 5, s);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pe_en && last_tap) begin found = 1'b1; break; end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (!found || {busy, done, cfg_err, rd_en, pe_en, first_tap, last_tap, out_valid} !== 8'b0 ||
            out_data !== 32'd0 || out_idx !== 8'd0) begin
            n_fail++;
            $display("FAIL drain_rst: found=%b ctrl=%b data=%0d idx=%0d want 1 00000000 0 0", found,
                     {busy, done, cfg_err, rd_en, pe_en, first_tap, last_tap, out_valid}, out_data, out_idx);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt != nd || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_abort: dones=%0d out_valid=%b want 0 0", done_cnt - nd, out_valid);
        end
        clear_rec();
        pulse_start(3, 5, s);
        wait_done(200, to);
        n_checks++;
        if (to || q_data.size() != 3) begin
            n_fail++; $display("FAIL drain_rerun: timeout=%b results=%0d want 0 3", to, q_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (q_data[i] !== 32'(exp_d[i]) || q_idx[i] !== ADDR_W'(i)) begin
                    n_fail++;
                    $display("FAIL drain_data[%0d]: data=%0d idx=%0d want %0d %0d", i, q_data[i], q_idx[i], exp_d[i], i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_err();
        test_k1();
        test_restart();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
